encoder_meas_ctrl: RTL and testbench

Measurement controller for the quadrature/tick encoder path. Synchronises the raw `ticks` input, opens a fixed-length counting gate on request (single-shot or continuous), counts rising tick edges inside the gate, then scales the count into an RPM value. It sits between the raw encoder pin and the software-visible `tick_count`/`rpm` registers, replacing free-running counting with a sequenced, gated measurement.

---
 rtl/encoder_pkg.sv | 25 ++
 rtl/encoder_meas_ctrl_if.sv | 18 +
 rtl/encoder_tick_sync.sv | 29 ++
 rtl/encoder_meas_ctrl.sv | 137 +++++++++++++
 tb/tb_encoder_meas_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/encoder_pkg.sv
// Shared FSM state type, default widths and the saturation helper
// for the encoder measurement path.
package encoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GATE,
    ST_CALC,
    ST_DONE
  } meas_state_t;

  localparam int DEF_GATE_CYCLES = 1000;
  localparam int DEF_RPM_SCALE   = 3;
  localparam int DEF_CNT_W       = 16;
  localparam int DEF_RPM_W       = 11;

  // Products are formed at this width so no scale/count combination can wrap.
  localparam int PROD_W = 64;

  function automatic logic [PROD_W-1:0] sat_clamp(input logic [PROD_W-1:0] value,
                                                  input logic [PROD_W-1:0] limit);
    return (value > limit) ? limit : value;
  endfunction

endpackage

// File: rtl/encoder_meas_ctrl_if.sv
// Software-facing request/result bundle of the encoder measurement controller.
interface encoder_meas_ctrl_if #(
  parameter int CNT_W = encoder_pkg::DEF_CNT_W,
  parameter int RPM_W = encoder_pkg::DEF_RPM_W
);

  logic             start;
  logic             cont;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] tick_count;
  logic [RPM_W-1:0] rpm;
  logic             ovf;

  modport master (output start, cont, input busy, done, tick_count, rpm, ovf);
  modport slave  (input start, cont, output busy, done, tick_count, rpm, ovf);

endinterface

// File: rtl/encoder_tick_sync.sv
// Two-flop synchroniser for the raw tick pin followed by a registered
// rising-edge detector; free-running regardless of clock enable.
module encoder_tick_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic ticks,
  output logic tick_edge
);

  logic sync_1;
  logic sync_2;
  logic sync_prev;

  // The edge pulse is registered so it lands three clocks after the pin rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_1    <= 1'b0;
      sync_2    <= 1'b0;
      sync_prev <= 1'b0;
      tick_edge <= 1'b0;
    end else begin
      sync_1    <= ticks;
      sync_2    <= sync_1;
      sync_prev <= sync_2;
      tick_edge <= sync_2 & ~sync_prev;
    end
  end

endmodule

// File: rtl/encoder_meas_ctrl.sv
// Gated tick counter: counts synchronised tick edges over a fixed window,
// scales the count to RPM with saturation and publishes registered results.
module encoder_meas_ctrl
  import encoder_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int RPM_SCALE   = DEF_RPM_SCALE,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RPM_W       = DEF_RPM_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ce,
  input  logic                ticks,
  encoder_meas_ctrl_if.slave  bus
);

  localparam int TIMER_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX    = '1;
  localparam logic [PROD_W-1:0]  RPM_MAX    = (PROD_W'(1) << RPM_W) - PROD_W'(1);

  meas_state_t        state;
  meas_state_t        state_next;
  logic               arm;
  logic               busy;
  logic               done;
  logic               tick_edge;
  logic [TIMER_W-1:0] gate_timer;
  logic [CNT_W-1:0]   work_count;
  logic               work_ovf;
  logic [PROD_W-1:0]  product;
  logic [RPM_W-1:0]   product_sat;
  logic               rpm_clip;
  logic [CNT_W-1:0]   tick_count_q;
  logic [RPM_W-1:0]   rpm_q;
  logic               ovf_q;

  encoder_tick_sync u_tick_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ticks     (ticks),
    .tick_edge (tick_edge)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else if (ce) begin
      state <= state_next;
    end
  end

  // arm marks the cycle that opens a fresh gate, from IDLE or a continuous re-arm.
  always_comb begin
    state_next = state;
    arm        = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start || bus.cont) begin
          state_next = ST_GATE;
          arm        = 1'b1;
        end
      end
      ST_GATE: begin
        busy = 1'b1;
        if (gate_timer == TIMER_LAST) begin
          state_next = ST_CALC;
        end
      end
      ST_CALC: begin
        busy       = 1'b1;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (bus.cont) begin
          state_next = ST_GATE;
          arm        = 1'b1;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign product     = PROD_W'(work_count) * PROD_W'(RPM_SCALE);
  assign rpm_clip    = product > RPM_MAX;
  assign product_sat = RPM_W'(sat_clamp(product, RPM_MAX));

  // Working count sticks at its maximum; later edges only raise the overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_timer <= '0;
      work_count <= '0;
      work_ovf   <= 1'b0;
    end else if (ce) begin
      if (arm) begin
        gate_timer <= '0;
        work_count <= '0;
        work_ovf   <= 1'b0;
      end else if (state == ST_GATE) begin
        gate_timer <= gate_timer + TIMER_W'(1);
        if (tick_edge) begin
          if (work_count == CNT_MAX) begin
            work_ovf <= 1'b1;
          end else begin
            work_count <= work_count + CNT_W'(1);
          end
        end
      end
    end
  end

  // Results are captured leaving CALC so they are visible alongside done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_count_q <= '0;
      rpm_q        <= '0;
      ovf_q        <= 1'b0;
    end else if (ce && (state == ST_CALC)) begin
      tick_count_q <= work_count;
      rpm_q        <= product_sat;
      ovf_q        <= work_ovf | rpm_clip;
    end
  end

  assign bus.busy       = busy;
  assign bus.done       = done;
  assign bus.tick_count = tick_count_q;
  assign bus.rpm        = rpm_q;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_encoder_meas_ctrl.sv
// Self-checking bench: four parameterisations checked every cycle against a
// timeline model, plus table-driven single shots and hand-written sequences.
module tb_encoder_meas_ctrl;
  import encoder_pkg::*;

  localparam int NDUT = 4;

  typedef struct {
    int half_per;
    int ce_pause;
    bit poke_start;
    int exp_lat;
    int tc_a;
    int rpm_a;
    bit ovf_a;
    int tc_b;
    int rpm_b;
    bit ovf_b;
    int tc_c;
    int rpm_c;
    bit ovf_c;
  } vec_t;

  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic ce_abc     = 1'b1;
  logic ce_d       = 1'b1;
  logic start_abc  = 1'b0;
  logic cont_abc   = 1'b0;
  logic start_d    = 1'b0;
  logic cont_d     = 1'b0;
  logic ticks_slow = 1'b0;
  logic ticks_fast = 1'b0;
  logic ticks_d    = 1'b0;
  int   half_per   = 50;
  int   checks     = 0;
  int   passed     = 0;
  vec_t vecs [4];

  always #10 clk = ~clk;

  encoder_meas_ctrl_if #(.CNT_W(16), .RPM_W(11)) bus_a ();
  encoder_meas_ctrl_if #(.CNT_W(16), .RPM_W(11)) bus_b ();
  encoder_meas_ctrl_if #(.CNT_W(4),  .RPM_W(11)) bus_c ();
  encoder_meas_ctrl_if #(.CNT_W(4),  .RPM_W(5))  bus_d ();

  assign bus_a.start = start_abc;
  assign bus_a.cont  = cont_abc;
  assign bus_b.start = start_abc;
  assign bus_b.cont  = cont_abc;
  assign bus_c.start = start_abc;
  assign bus_c.cont  = cont_abc;
  assign bus_d.start = start_d;
  assign bus_d.cont  = cont_d;

  encoder_meas_ctrl #(.GATE_CYCLES(1000), .RPM_SCALE(3), .CNT_W(16), .RPM_W(11)) dut_a (
    .clk(clk), .rst_n(rst_n), .ce(ce_abc), .ticks(ticks_slow), .bus(bus_a));
  encoder_meas_ctrl #(.GATE_CYCLES(1000), .RPM_SCALE(300), .CNT_W(16), .RPM_W(11)) dut_b (
    .clk(clk), .rst_n(rst_n), .ce(ce_abc), .ticks(ticks_slow), .bus(bus_b));
  encoder_meas_ctrl #(.GATE_CYCLES(1000), .RPM_SCALE(3), .CNT_W(4), .RPM_W(11)) dut_c (
    .clk(clk), .rst_n(rst_n), .ce(ce_abc), .ticks(ticks_fast), .bus(bus_c));
  encoder_meas_ctrl #(.GATE_CYCLES(40), .RPM_SCALE(3), .CNT_W(4), .RPM_W(5)) dut_d (
    .clk(clk), .rst_n(rst_n), .ce(ce_d), .ticks(ticks_d), .bus(bus_d));

  // Reference model: each measurement is a timeline of ce-high cycles after acceptance.
  int         g_len [NDUT] = '{1000, 1000, 1000, 40};
  int         scale [NDUT] = '{3, 300, 3, 3};
  int         cmax  [NDUT] = '{65535, 65535, 15, 15};
  int         rmax  [NDUT] = '{2047, 2047, 2047, 31};
  bit         m_active [NDUT];
  int         m_phase  [NDUT];
  int         m_cnt    [NDUT];
  bit         m_cov    [NDUT];
  int         e_tc     [NDUT];
  int         e_rpm    [NDUT];
  bit         e_ovf    [NDUT];
  logic [4:0] hist     [NDUT];
  logic       in_ce    [NDUT];
  logic       in_start [NDUT];
  logic       in_cont  [NDUT];
  logic       in_tick  [NDUT];
  logic [29:0] obs     [NDUT];

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    checks++;
    if (actual == expected) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelStep(input int i);
    logic        pulse;
    logic        exp_busy;
    logic        exp_done;
    longint      prod;
    logic [29:0] expv;
    hist[i] = {hist[i][3:0], in_tick[i]};
    if (!rst_n) begin
      hist[i]     = '0;
      m_active[i] = 1'b0;
      m_phase[i]  = 0;
      m_cnt[i]    = 0;
      m_cov[i]    = 1'b0;
      e_tc[i]     = 0;
      e_rpm[i]    = 0;
      e_ovf[i]    = 1'b0;
      checkOutput($sformatf("dut%0d_reset_outputs", i), obs[i], 0);
      return;
    end
    // A pin rise in cycle c becomes a counted edge in cycle c+3.
    pulse    = hist[i][3] & ~hist[i][4];
    exp_busy = m_active[i] && (m_phase[i] >= 1) && (m_phase[i] <= g_len[i] + 1);
    exp_done = m_active[i] && (m_phase[i] == g_len[i] + 2);
    expv     = {exp_busy, exp_done, e_ovf[i], 16'(e_tc[i]), 11'(e_rpm[i])};
    checkOutput($sformatf("dut%0d_cycle_outputs", i), obs[i], expv);
    if (!m_active[i]) begin
      if (in_ce[i] && (in_start[i] || in_cont[i])) begin
        m_active[i] = 1'b1;
        m_phase[i]  = 1;
        m_cnt[i]    = 0;
        m_cov[i]    = 1'b0;
      end
    end else if (in_ce[i]) begin
      if (m_phase[i] <= g_len[i]) begin
        if (pulse) begin
          if (m_cnt[i] == cmax[i]) m_cov[i] = 1'b1;
          else m_cnt[i]++;
        end
        m_phase[i]++;
      end else if (m_phase[i] == g_len[i] + 1) begin
        prod     = longint'(m_cnt[i]) * longint'(scale[i]);
        e_tc[i]  = m_cnt[i];
        e_rpm[i] = (prod > rmax[i]) ? rmax[i] : int'(prod);
        e_ovf[i] = m_cov[i] || (prod > rmax[i]);
        m_phase[i]++;
      end else if (in_cont[i]) begin
        m_phase[i] = 1;
        m_cnt[i]   = 0;
        m_cov[i]   = 1'b0;
      end else begin
        m_active[i] = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    in_ce    = '{ce_abc, ce_abc, ce_abc, ce_d};
    in_start = '{start_abc, start_abc, start_abc, start_d};
    in_cont  = '{cont_abc, cont_abc, cont_abc, cont_d};
    in_tick  = '{ticks_slow, ticks_slow, ticks_fast, ticks_d};
    obs[0]   = {bus_a.busy, bus_a.done, bus_a.ovf, bus_a.tick_count, bus_a.rpm};
    obs[1]   = {bus_b.busy, bus_b.done, bus_b.ovf, bus_b.tick_count, bus_b.rpm};
    obs[2]   = {bus_c.busy, bus_c.done, bus_c.ovf, 12'd0, bus_c.tick_count, bus_c.rpm};
    obs[3]   = {bus_d.busy, bus_d.done, bus_d.ovf, 12'd0, bus_d.tick_count, 6'd0, bus_d.rpm};
    for (int i = 0; i < NDUT; i++) modelStep(i);
  end

  initial begin
    forever begin
      repeat (half_per) @(posedge clk);
      #1;
      ticks_slow = ~ticks_slow;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      ticks_fast = ~ticks_fast;
    end
  end

  task automatic applyStimulus(input vec_t v, input int r);
    bit got = 1'b0;
    int lat = -1;
    half_per = v.half_per;
    repeat (4 * v.half_per + 20) step();
    start_abc = 1'b1;
    for (int k = 1; k <= 4000 && !got; k++) begin
      step();
      if (k == 1) start_abc = 1'b0;
      if (v.poke_start && (k == 100 || k == 900)) start_abc = 1'b1;
      if (v.poke_start && (k == 101 || k == 901)) start_abc = 1'b0;
      if (v.ce_pause > 0 && k == 300) ce_abc = 1'b0;
      if (v.ce_pause > 0 && k == 300 + v.ce_pause) ce_abc = 1'b1;
      @(negedge clk);
      if (bus_a.done) begin
        got = 1'b1;
        lat = k;
      end
    end
    checkOutput($sformatf("row%0d_done_latency", r), lat, v.exp_lat);
    checkOutput($sformatf("row%0d_done_b_c", r), {bus_b.done, bus_c.done}, 3);
    checkOutput($sformatf("row%0d_a_tick_count", r), bus_a.tick_count, v.tc_a);
    checkOutput($sformatf("row%0d_a_rpm", r), bus_a.rpm, v.rpm_a);
    checkOutput($sformatf("row%0d_a_ovf", r), bus_a.ovf, v.ovf_a);
    checkOutput($sformatf("row%0d_b_tick_count", r), bus_b.tick_count, v.tc_b);
    checkOutput($sformatf("row%0d_b_rpm", r), bus_b.rpm, v.rpm_b);
    checkOutput($sformatf("row%0d_b_ovf", r), bus_b.ovf, v.ovf_b);
    checkOutput($sformatf("row%0d_c_tick_count", r), bus_c.tick_count, v.tc_c);
    checkOutput($sformatf("row%0d_c_rpm", r), bus_c.rpm, v.rpm_c);
    checkOutput($sformatf("row%0d_c_ovf", r), bus_c.ovf, v.ovf_c);
    repeat (3) step();
    ce_abc = 1'b1;
  endtask

  task automatic runContinuous();
    int done_cyc [$];
    int extra = 0;
    half_per = 50;
    repeat (220) step();
    cont_abc = 1'b1;
    for (int k = 1; k <= 4000 && done_cyc.size() < 3; k++) begin
      step();
      @(negedge clk);
      if (bus_a.done) begin
        done_cyc.push_back(k);
        checkOutput("cont_tick_count_10_pm1",
                    (bus_a.tick_count >= 9 && bus_a.tick_count <= 11), 1);
      end
    end
    checkOutput("cont_done_count", done_cyc.size(), 3);
    checkOutput("cont_first_latency", (done_cyc.size() > 0) ? done_cyc[0] : -1, 1002);
    checkOutput("cont_period_1", (done_cyc.size() == 3) ? done_cyc[1] - done_cyc[0] : -1, 1002);
    checkOutput("cont_period_2", (done_cyc.size() == 3) ? done_cyc[2] - done_cyc[1] : -1, 1002);
    repeat (400) step();
    cont_abc = 1'b0;
    for (int k = 0; k < 1500; k++) begin
      step();
      @(negedge clk);
      if (bus_a.done) extra++;
    end
    checkOutput("cont_drop_extra_done", extra, 1);
    checkOutput("cont_drop_idle_busy", bus_a.busy, 0);
  endtask

  task automatic runResetMidGate();
    int dones = 0;
    step();
    start_abc = 1'b1;
    step();
    start_abc = 1'b0;
    repeat (300) step();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("reset_busy", bus_a.busy, 0);
    checkOutput("reset_done", bus_a.done, 0);
    checkOutput("reset_tick_count", bus_a.tick_count, 0);
    checkOutput("reset_rpm", bus_a.rpm, 0);
    checkOutput("reset_ovf_b", bus_b.ovf, 0);
    step();
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 1100; k++) begin
      step();
      @(negedge clk);
      if (bus_a.done) dones++;
    end
    checkOutput("reset_no_done_after", dones, 0);
    checkOutput("reset_idle_busy", bus_a.busy, 0);
  endtask

  task automatic runRandom();
    int dones_d = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (k[5]) ticks_d = ~ticks_d;
      else ticks_d = 1'($urandom_range(0, 1));
      ce_d    = ($urandom_range(0, 7) != 0);
      start_d = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 99) == 0) cont_d = ~cont_d;
      @(negedge clk);
      if (bus_d.done) dones_d++;
    end
    checkOutput("rand_d_measurements_completed", (dones_d > 0), 1);
  endtask

  initial begin
    vecs[0] = '{50,   0, 1'b0, 1002,  10,  30, 1'b0,  10, 2047, 1'b1, 15, 45, 1'b1};
    vecs[1] = '{50, 500, 1'b1, 1502,  10,  30, 1'b0,  10, 2047, 1'b1, 15, 45, 1'b1};
    vecs[2] = '{25,   0, 1'b1, 1002,  20,  60, 1'b0,  20, 2047, 1'b1, 15, 45, 1'b1};
    vecs[3] = '{5,    0, 1'b0, 1002, 100, 300, 1'b0, 100, 2047, 1'b1, 15, 45, 1'b1};
    rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    @(negedge clk);
    checkOutput("post_reset_a_outputs",
                {bus_a.busy, bus_a.done, bus_a.ovf, bus_a.tick_count, bus_a.rpm}, 0);
    for (int r = 0; r < 4; r++) applyStimulus(vecs[r], r);
    runContinuous();
    runResetMidGate();
    runRandom();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
